led_array_ctrl: RTL and testbench

Parametrised successor to the registered LED output stage. Drives `N_LED` board LEDs from one clock. Each channel is independently configured as off, direct (registered follow of `LED_I`), PWM brightness, or blinking PWM. Sits between the top-level user logic/register bus and the LED pins. Configuration changes are applied only at PWM frame boundaries, so LEDs never glitch mid-frame.

---
 rtl/led_array_ctrl.sv | 127 ++++++++++++
 tb/tb_led_array_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_array_ctrl.sv
// led_array_ctrl: N_LED-channel LED driver. Each channel is OFF, DIRECT, PWM
// or BLINK. Config goes into a shadow copy, and the shadow is copied into the
// active set only at PWM frame boundaries, so outputs never glitch mid-frame.
module led_array_ctrl #(
  parameter  int N_LED    = 16,
  parameter  int PWM_W    = 8,
  parameter  int PRESC    = 100,
  parameter  int BLINK_FR = 64,
  localparam int AW       = (N_LED > 1) ? $clog2(N_LED) : 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_LED-1:0] LED_I,
  input  logic             CFG_WE,
  input  logic [AW-1:0]    CFG_ADDR,
  input  logic [1:0]       CFG_MODE,
  input  logic [PWM_W-1:0] CFG_DUTY,
  output logic             CFG_ACK,
  output logic [N_LED-1:0] LED_O,
  output logic             FRAME_O
);

  localparam int PC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int BF_W = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_DIRECT = 2'b01,
    MODE_PWM    = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  logic [PC_W-1:0]  pc;
  logic [PWM_W-1:0] pwm;
  logic [BF_W-1:0]  bf;
  logic             phase;
  logic             step;
  logic             frame;
  logic             wr_ok;

  mode_e            shd_mode [N_LED];
  logic [PWM_W-1:0] shd_duty [N_LED];
  mode_e            act_mode [N_LED];
  logic [PWM_W-1:0] act_duty [N_LED];
  logic [N_LED-1:0] led_nxt;

  assign step  = (pc == PC_W'(PRESC - 1));
  assign frame = step && (pwm == '1);
  assign wr_ok = CFG_WE && ({{(32-AW){1'b0}}, CFG_ADDR} < N_LED);

  // Prescaler, PWM step counter and blink frame counter / phase.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc    <= '0;
      pwm   <= '0;
      bf    <= '0;
      phase <= 1'b1;
    end else begin
      if (step) begin
        pc  <= '0;
        pwm <= pwm + 1'b1;
      end else begin
        pc  <= pc + 1'b1;
      end
      if (frame) begin
        if (bf == BF_W'(BLINK_FR - 1)) begin
          bf    <= '0;
          phase <= ~phase;
        end else begin
          bf <= bf + 1'b1;
        end
      end
    end
  end

  // Shadow writes and frame-boundary load of the active set. The active load
  // samples the pre-edge shadow, so a write in the frame cycle waits a frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      CFG_ACK <= 1'b0;
      for (int unsigned i = 0; i < N_LED; i++) begin
        shd_mode[i] <= MODE_OFF;
        shd_duty[i] <= '0;
        act_mode[i] <= MODE_OFF;
        act_duty[i] <= '0;
      end
    end else begin
      CFG_ACK <= wr_ok;
      if (wr_ok) begin
        shd_mode[CFG_ADDR] <= mode_e'(CFG_MODE);
        shd_duty[CFG_ADDR] <= CFG_DUTY;
      end
      if (frame) begin
        for (int unsigned i = 0; i < N_LED; i++) begin
          act_mode[i] <= shd_mode[i];
          act_duty[i] <= shd_duty[i];
        end
      end
    end
  end

  // Per-channel next LED value from the active configuration.
  always_comb begin
    led_nxt = '0;
    for (int unsigned i = 0; i < N_LED; i++) begin
      unique case (act_mode[i])
        MODE_OFF:    led_nxt[i] = 1'b0;
        MODE_DIRECT: led_nxt[i] = LED_I[i];
        MODE_PWM:    led_nxt[i] = (pwm < act_duty[i]);
        MODE_BLINK:  led_nxt[i] = (pwm < act_duty[i]) && phase;
        default:     led_nxt[i] = 1'b0;
      endcase
    end
  end

  // Registered LED drive and frame-boundary pulse.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LED_O   <= '0;
      FRAME_O <= 1'b0;
    end else begin
      LED_O   <= led_nxt;
      FRAME_O <= frame;
    end
  end

endmodule

// File: tb/tb_led_array_ctrl.sv
// Scoreboard bench for led_array_ctrl. A 4-channel DUT and a 3-channel DUT
// share stimulus; the 3-channel one has an unrepresentable-by-array address (3)
// and must ignore writes to it. Expected outputs come from a timeline model.
`timescale 1ns/1ps
module tb_led_array_ctrl;

  localparam int NL = 4;
  localparam int W  = 3;
  localparam int PR = 2;
  localparam int BF = 2;
  localparam int FL = PR * (1 << W);

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [NL-1:0] LED_I;
  logic          CFG_WE;
  logic [1:0]    CFG_ADDR;
  logic [1:0]    CFG_MODE;
  logic [W-1:0]  CFG_DUTY;
  logic          ack4, frm4, ack3, frm3;
  logic [NL-1:0] led4;
  logic [2:0]    led3;

  led_array_ctrl #(.N_LED(4), .PWM_W(W), .PRESC(PR), .BLINK_FR(BF)) dut (
    .CLK(CLK), .RST_N(RST_N), .LED_I(LED_I), .CFG_WE(CFG_WE),
    .CFG_ADDR(CFG_ADDR), .CFG_MODE(CFG_MODE), .CFG_DUTY(CFG_DUTY),
    .CFG_ACK(ack4), .LED_O(led4), .FRAME_O(frm4)
  );

  led_array_ctrl #(.N_LED(3), .PWM_W(W), .PRESC(PR), .BLINK_FR(BF)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .LED_I(LED_I[2:0]), .CFG_WE(CFG_WE),
    .CFG_ADDR(CFG_ADDR), .CFG_MODE(CFG_MODE), .CFG_DUTY(CFG_DUTY),
    .CFG_ACK(ack3), .LED_O(led3), .FRAME_O(frm3)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] led;
    logic       ack;
    logic       frm;
    logic [2:0] led3;
    logic       ack3;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Model state: edges since reset release, shadow and active configuration.
  int  n;
  int  shd_m[NL], shd_d[NL], act_m[NL], act_d[NL];
  bit  force_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < NL; i++) begin
      shd_m[i] = 0; shd_d[i] = 0; act_m[i] = 0; act_d[i] = 0;
    end
  endtask

  // One clock: drive at negedge, predict the outputs after the next posedge,
  // then advance the model past that edge.
  task automatic step_cycle(input bit we, input int addr, input int mode, input int duty);
    exp_t       e;
    logic [3:0] li;
    int         pwm;
    bit         phase;
    li       = force_on ? 4'hF : 4'($urandom);
    LED_I    = li;
    CFG_WE   = we;
    CFG_ADDR = 2'(addr);
    CFG_MODE = 2'(mode);
    CFG_DUTY = W'(duty);
    pwm   = (n / PR) % (1 << W);
    phase = (((n / FL) / BF) % 2) == 0;
    for (int i = 0; i < NL; i++) begin
      case (act_m[i])
        1:       e.led[i] = li[i];
        2:       e.led[i] = (pwm < act_d[i]);
        3:       e.led[i] = (pwm < act_d[i]) && phase;
        default: e.led[i] = 1'b0;
      endcase
    end
    e.ack  = we;
    e.frm  = (n % FL) == FL - 1;
    e.led3 = e.led[2:0];
    e.ack3 = we && (addr < 3);
    q.push_back(e);
    @(posedge CLK);
    if ((n % FL) == FL - 1)
      for (int i = 0; i < NL; i++) begin
        act_m[i] = shd_m[i]; act_d[i] = shd_d[i];
      end
    if (we) begin
      shd_m[addr] = mode; shd_d[addr] = duty;
    end
    n++;
    @(negedge CLK);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) step_cycle(1'b0, 0, 0, 0);
  endtask

  function automatic int pick_duty();
    int s;
    s = $urandom_range(0, 3);
    if (s == 0) return 0;
    if (s == 1) return (1 << W) - 1;
    return $urandom_range(0, (1 << W) - 1);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_led4"},  64'(led4), 64'd0);
    check({tag, "_ack4"},  64'(ack4), 64'd0);
    check({tag, "_frm4"},  64'(frm4), 64'd0);
    check({tag, "_led3"},  64'(led3), 64'd0);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction each cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("led_o",    64'(led4), 64'(e.led));
        check("cfg_ack",  64'(ack4), 64'(e.ack));
        check("frame_o",  64'(frm4), 64'(e.frm));
        check("led_o_n3", 64'(led3), 64'(e.led3));
        check("ack_n3",   64'(ack3), 64'(e.ack3));
        check("frame_n3", 64'(frm3), 64'(e.frm));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    RST_N = 1'b0; LED_I = 4'hF; CFG_WE = 1'b0;
    CFG_ADDR = '0; CFG_MODE = '0; CFG_DUTY = '0;
    model_reset();
    repeat (3) @(negedge CLK);
    check_reset_outputs("rst_hold");
    RST_N = 1'b1;

    // Idle after reset: all OFF, frame pulses every FL cycles.
    idle(40);

    // Directed setup: ch0 DIRECT, ch1 PWM 3, ch2 BLINK 7, held for blink periods.
    step_cycle(1'b1, 0, 1, 0);
    step_cycle(1'b1, 1, 2, 3);
    step_cycle(1'b1, 2, 3, 7);
    idle(140);
    // Back-to-back writes to ch1; the last one before the boundary wins.
    step_cycle(1'b1, 1, 2, 0);
    step_cycle(1'b1, 1, 2, 7);
    idle(40);
    step_cycle(1'b1, 1, 2, 0);
    idle(36);
    // ch3 PWM duty 4 written exactly in the frame cycle.
    while ((n % FL) != FL - 1) step_cycle(1'b0, 0, 0, 0);
    step_cycle(1'b1, 3, 2, 4);
    idle(40);
    // Write to address 3: accepted by 4-channel DUT, ignored by 3-channel DUT.
    step_cycle(1'b1, 3, 1, 0);
    idle(20);

    // Sparse random configuration.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0)
        step_cycle(1'b1, $urandom_range(0, 3), $urandom_range(0, 3), pick_duty());
      else
        step_cycle(1'b0, 0, 0, 0);
    end
    // Writes only in frame cycles.
    for (int k = 0; k < 160; k++) begin
      if ((n % FL) == FL - 1)
        step_cycle(1'b1, $urandom_range(0, 3), $urandom_range(0, 3), pick_duty());
      else
        step_cycle(1'b0, 0, 0, 0);
    end
    // Back-to-back writes every cycle.
    for (int k = 0; k < 60; k++)
      step_cycle(1'b1, $urandom_range(0, 3), $urandom_range(0, 3), pick_duty());
    idle(40);

    // All channels DIRECT with LED_I all-ones, then reset mid-frame.
    force_on = 1'b1;
    for (int i = 0; i < NL; i++) step_cycle(1'b1, i, 1, 0);
    idle(FL);
    while ((n % FL) != FL / 2) step_cycle(1'b0, 0, 0, 0);
    #2;
    RST_N = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(negedge CLK);
    check_reset_outputs("rst_mid");
    force_on = 1'b0;
    RST_N = 1'b1;
    model_reset();
    idle(40);

    // Random again after reset.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 5) == 0)
        step_cycle(1'b1, $urandom_range(0, 3), $urandom_range(0, 3), pick_duty());
      else
        step_cycle(1'b0, 0, 0, 0);
    end

    check("queue_drained", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
